// File: rtl/window_mem.sv
`default_nettype none
// ============================================================================
// Module   : window_mem
// Desc     : Multi-lane scratch memory: single-word writes, LANES-wide window
//            writes sequenced over WR_PORTS write ports, and registered
//            LANES-wide window reads. Macro WINMEM_BOUNDS_CHECK_EN rejects
//            windows that would cross the end of the array.
// Revision : 1.0 - initial release
// ============================================================================
module window_mem #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 2048,
  parameter int LANES    = 50,
  parameter int WR_PORTS = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [$clog2(DEPTH)-1:0]  req_addr,
  input  logic [DATA_W-1:0]         wr_word,
  input  logic [LANES*DATA_W-1:0]   wr_lanes,
  output logic                      rd_valid,
  output logic [LANES*DATA_W-1:0]   rd_lanes,
  output logic                      wr_done,
  output logic                      err
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_G      = (LANES + WR_PORTS - 1) / WR_PORTS;
  localparam int c_GW     = (c_G > 1) ? $clog2(c_G) : 1;

  localparam logic [1:0] c_OP_SWR = 2'b00;
  localparam logic [1:0] c_OP_WWR = 2'b01;
  localparam logic [1:0] c_OP_RD  = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_WBURST = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      r_ready;
  logic                      r_rd_valid;
  logic                      r_wr_done;
  logic                      r_err;
  logic [LANES*DATA_W-1:0]   r_rd_lanes;
  logic [LANES*DATA_W-1:0]   r_stage;
  logic [c_ADDR_W-1:0]       r_base;
  logic [c_GW-1:0]           r_grp;

  logic                      w_accept;
  logic                      w_oob;
  logic                      w_load;
  logic                      w_rd_fire;
  logic                      w_done_next;
  logic                      w_err_next;
  logic [WR_PORTS-1:0]       w_we;
  logic [c_ADDR_W-1:0]       w_waddr [WR_PORTS];
  logic [DATA_W-1:0]         w_wdata [WR_PORTS];

  assign w_accept = req_valid && req_ready;

`ifdef WINMEM_BOUNDS_CHECK_EN
  // Largest base whose window still ends inside the array.
  localparam logic [c_ADDR_W:0] c_LIMIT = (c_ADDR_W + 1)'(DEPTH - LANES);
  assign w_oob = ((req_op == c_OP_WWR) || (req_op == c_OP_RD)) &&
                 ({1'b0, req_addr} > c_LIMIT);
`else
  assign w_oob = 1'b0;
`endif

  always_comb begin
    int lane;
    lane         = 0;
    w_state_next = r_state;
    w_load       = 1'b0;
    w_rd_fire    = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_we         = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      w_waddr[p] = '0;
      w_wdata[p] = '0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_oob) begin
            w_err_next = 1'b1;
          end else begin
            case (req_op)
              c_OP_SWR: begin
                w_we[0]     = 1'b1;
                w_waddr[0]  = req_addr;
                w_wdata[0]  = wr_word;
                w_done_next = 1'b1;
              end
              c_OP_WWR: begin
                // Group 0 goes straight from the request; the rest from staging.
                w_load = 1'b1;
                for (int p = 0; p < WR_PORTS; p++) begin
                  w_we[p]    = 1'b1;
                  w_waddr[p] = req_addr + c_ADDR_W'(p);
                  w_wdata[p] = wr_lanes[p*DATA_W +: DATA_W];
                end
                if (c_G > 1) begin
                  w_state_next = S_WBURST;
                end else begin
                  w_done_next = 1'b1;
                end
              end
              c_OP_RD: begin
                w_rd_fire = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      S_WBURST: begin
        for (int p = 0; p < WR_PORTS; p++) begin
          lane = int'(r_grp) * WR_PORTS + p;
          if (lane < LANES) begin
            w_we[p]    = 1'b1;
            w_waddr[p] = r_base + c_ADDR_W'(lane);
            w_wdata[p] = r_stage[lane*DATA_W +: DATA_W];
          end
        end
        if (r_grp == c_GW'(c_G - 1)) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_err      <= 1'b0;
      r_grp      <= '0;
      r_rd_lanes <= '0;
    end else begin
      r_ready    <= (w_state_next == S_IDLE);
      r_rd_valid <= w_rd_fire;
      r_wr_done  <= w_done_next;
      r_err      <= w_err_next;
      if (w_load) begin
        r_grp <= c_GW'(1);
      end else if (r_state == S_WBURST) begin
        r_grp <= r_grp + c_GW'(1);
      end
      if (w_rd_fire) begin
        for (int i = 0; i < LANES; i++) begin
          r_rd_lanes[i*DATA_W +: DATA_W] <= mem[req_addr + c_ADDR_W'(i)];
        end
      end
    end
  end

  // Staging data needs no reset: it is only consumed after a load.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_stage <= wr_lanes;
      r_base  <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < WR_PORTS; p++) begin
      if (w_we[p]) begin
        mem[w_waddr[p]] <= w_wdata[p];
      end
    end
  end

  assign req_ready = r_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_lanes  = r_rd_lanes;
  assign wr_done   = r_wr_done;
`ifdef WINMEM_BOUNDS_CHECK_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_mem
// Desc     : Directed bench for window_mem: default build (WR_PORTS=10) and a
//            partial-last-group build (WR_PORTS=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_mem;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;
  localparam int LANES = 50;
  localparam int AW    = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             a_valid, a_ready, a_rdv, a_done, a_err;
  logic [1:0]       a_op;
  logic [AW-1:0]    a_addr;
  logic [DW-1:0]    a_word;
  logic [LANES*DW-1:0] a_lanes, a_rd;

  logic             b_valid, b_ready, b_rdv, b_done, b_err;
  logic [1:0]       b_op;
  logic [AW-1:0]    b_addr;
  logic [DW-1:0]    b_word;
  logic [LANES*DW-1:0] b_lanes, b_rd;

  int n_cmp = 0;
  int n_bad = 0;

  window_mem #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(LANES), .WR_PORTS(10)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
    .req_addr(a_addr), .wr_word(a_word), .wr_lanes(a_lanes), .rd_valid(a_rdv),
    .rd_lanes(a_rd), .wr_done(a_done), .err(a_err)
  );

  window_mem #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(LANES), .WR_PORTS(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
    .req_addr(b_addr), .wr_word(b_word), .wr_lanes(b_lanes), .rd_valid(b_rdv),
    .rd_lanes(b_rd), .wr_done(b_done), .err(b_err)
  );

  function automatic logic [LANES*DW-1:0] pat(input int off, input int step);
    logic [LANES*DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 8'(off + step * i);
    return v;
  endfunction

  // Presents one request at a negedge; returns 1 time unit after its accept edge.
  task automatic issue(input int u, input logic [1:0] op, input int addr,
                       input logic [DW-1:0] w, input logic [LANES*DW-1:0] ln);
    int t;
    t = 0;
    @(negedge clk);
    while (((u == 0) ? a_ready : b_ready) !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_ready_timeout unit=%0d ready stayed low, required 1", u);
    end
    if (u == 0) begin
      a_valid = 1'b1; a_op = op; a_addr = AW'(addr); a_word = w; a_lanes = ln;
    end else begin
      b_valid = 1'b1; b_op = op; b_addr = AW'(addr); b_word = w; b_lanes = ln;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wwrite_wait(input int u, input int addr, input logic [LANES*DW-1:0] ln);
    int t;
    t = 0;
    issue(u, 2'b01, addr, '0, ln);
    while (((u == 0) ? a_ready : b_ready) !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL wwrite_timeout unit=%0d ready stayed low, required 1", u);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 0; a_op = 0; a_addr = 0; a_word = 0; a_lanes = '0;
    b_valid = 0; b_op = 0; b_addr = 0; b_word = 0; b_lanes = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_ready, a_rdv, a_done, a_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got %b required 0000", {a_ready, a_rdv, a_done, a_err});
    end
    n_cmp++;
    if (a_rd !== '0) begin
      n_bad++;
      $display("FAIL reset_rd_lanes got nonzero lane0=%h required 0", a_rd[7:0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({a_ready, b_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_release_ready got %b required 11", {a_ready, b_ready});
    end
  endtask

  task automatic test_single_write();
    issue(0, 2'b00, 1000, 8'h10, '0);
    n_cmp++;
    if ({a_done, a_rdv} !== 2'b10) begin
      n_bad++;
      $display("FAIL swr_done got done,rdv=%b required 10", {a_done, a_rdv});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_done !== 1'b0) begin
      n_bad++;
      $display("FAIL swr_done_pulse got %b required 0", a_done);
    end
    issue(0, 2'b10, 1000, '0, '0);
    n_cmp++;
    if (a_rdv !== 1'b1 || a_rd[7:0] !== 8'h10) begin
      n_bad++;
      $display("FAIL swr_read got rdv=%b lane0=%h required 1 10", a_rdv, a_rd[7:0]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_rdv !== 1'b0 || a_rd[7:0] !== 8'h10) begin
      n_bad++;
      $display("FAIL rd_hold got rdv=%b lane0=%h required 0 10", a_rdv, a_rd[7:0]);
    end
  endtask

  task automatic test_window_write();
    int lows, bad;
    logic [DW-1:0] want;
    lows = 0;
    issue(0, 2'b01, 200, '0, pat(1, 1));
    while (a_ready !== 1'b1 && lows < 20) begin
      lows++; @(posedge clk); #1;
    end
    n_cmp++;
    if (lows != 4 || a_done !== 1'b1) begin
      n_bad++;
      $display("FAIL ww_ready_low got %0d cycles done=%b required 4 1", lows, a_done);
    end
    issue(0, 2'b10, 200, '0, '0);
    bad = -1; want = '0;
    for (int i = 0; i < LANES; i++)
      if (bad < 0 && a_rd[i*DW +: DW] !== 8'(i + 1)) begin bad = i; want = 8'(i + 1); end
    n_cmp++;
    if (a_rdv !== 1'b1 || bad >= 0) begin
      n_bad++;
      $display("FAIL ww_read rdv=%b lane %0d got %h required %h", a_rdv, bad,
               (bad >= 0) ? a_rd[bad*DW +: DW] : 8'h00, want);
    end
  endtask

  task automatic test_partial_group();
    int lows, bad;
    logic [DW-1:0] want;
    lows = 0;
    issue(1, 2'b00, 250, 8'hAA, '0);
    issue(1, 2'b01, 200, '0, pat(8'h40, 1));
    while (b_ready !== 1'b1 && lows < 20) begin
      lows++; @(posedge clk); #1;
    end
    n_cmp++;
    if (lows != 3 || b_done !== 1'b1) begin
      n_bad++;
      $display("FAIL pg_ready_low got %0d cycles done=%b required 3 1", lows, b_done);
    end
    issue(1, 2'b10, 200, '0, '0);
    bad = -1; want = '0;
    for (int i = 0; i < LANES; i++)
      if (bad < 0 && b_rd[i*DW +: DW] !== 8'(8'h40 + i)) begin bad = i; want = 8'(8'h40 + i); end
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL pg_read lane %0d got %h required %h", bad, b_rd[bad*DW +: DW], want);
    end
    n_cmp++;
    if (b_rd[49*DW +: DW] !== 8'h71 || b_rd[48*DW +: DW] !== 8'h70) begin
      n_bad++;
      $display("FAIL pg_last_lanes got %h %h required 70 71", b_rd[48*DW +: DW], b_rd[49*DW +: DW]);
    end
    issue(1, 2'b10, 250, '0, '0);
    n_cmp++;
    if (b_rd[7:0] !== 8'hAA) begin
      n_bad++;
      $display("FAIL pg_beyond_window got %h required aa", b_rd[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [LANES*DW-1:0] exp_w [3];
    exp_w[0] = pat(8'h80, 1);
    exp_w[1] = pat(8'hC0, 1);
    exp_w[2] = pat(255, -1);
    wwrite_wait(0, 0, exp_w[0]);
    wwrite_wait(0, 50, exp_w[1]);
    wwrite_wait(0, 100, exp_w[2]);
    @(negedge clk);
    a_valid = 1'b1; a_op = 2'b10; a_addr = 11'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bad = -1;
      for (int i = 0; i < LANES; i++)
        if (bad < 0 && a_rd[i*DW +: DW] !== exp_w[k][i*DW +: DW]) bad = i;
      n_cmp++;
      if (a_rdv !== 1'b1 || a_ready !== 1'b1 || bad >= 0) begin
        n_bad++;
        $display("FAIL b2b_read%0d rdv=%b ready=%b first bad lane %0d, required 1 1 none",
                 k, a_rdv, a_ready, bad);
      end
      if (k == 2) a_valid = 1'b0;
      else a_addr = AW'(50 * (k + 1));
    end
    @(negedge clk);
    n_cmp++;
    if (a_rdv !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end rdv got %b required 0", a_rdv);
    end
  endtask

  task automatic test_reserved();
    issue(0, 2'b11, 5, 8'h55, pat(1, 1));
    n_cmp++;
    if ({a_rdv, a_done, a_err, a_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reserved rdv,done,err,ready got %b required 0001", {a_rdv, a_done, a_err, a_ready});
    end
  endtask

  task automatic test_reset_midburst();
    int bad;
    logic [DW-1:0] want;
    wwrite_wait(0, 400, pat(8'h20, 1));
    issue(0, 2'b01, 400, '0, pat(8'h90, 1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_ready, a_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_rst_flags ready,done got %b required 00", {a_ready, a_done});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({a_ready, a_done} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_rst_release ready,done got %b required 10", {a_ready, a_done});
    end
    issue(0, 2'b10, 400, '0, '0);
    bad = -1; want = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [DW-1:0] e;
      e = (i < 20) ? 8'(8'h90 + i) : 8'(8'h20 + i);
      if (bad < 0 && a_rd[i*DW +: DW] !== e) begin bad = i; want = e; end
    end
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL mid_rst_mem lane %0d got %h required %h", bad, a_rd[bad*DW +: DW], want);
    end
  endtask

  task automatic test_wrap();
    int bad;
    logic [DW-1:0] want;
    for (int j = 0; j < 8; j++) issue(0, 2'b00, 2040 + j, 8'(8'h30 + j), '0);
`ifdef WINMEM_BOUNDS_CHECK_EN
    issue(0, 2'b10, 2040, '0, '0);
    n_cmp++;
    if ({a_err, a_rdv, a_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL oob_read err,rdv,ready got %b required 101", {a_err, a_rdv, a_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_err_pulse got %b required 0", a_err);
    end
    issue(0, 2'b01, 2040, '0, pat(8'hEE, 0));
    n_cmp++;
    if ({a_err, a_done, a_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL oob_write err,done,ready got %b required 101", {a_err, a_done, a_ready});
    end
    issue(0, 2'b10, 1998, '0, '0);
    bad = -1; want = '0;
    for (int i = 42; i < LANES; i++)
      if (bad < 0 && a_rd[i*DW +: DW] !== 8'(8'h30 + i - 42)) begin bad = i; want = 8'(8'h30 + i - 42); end
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL oob_mem_unchanged lane %0d got %h required %h", bad, a_rd[bad*DW +: DW], want);
    end
    issue(0, 2'b10, 0, '0, '0);
    bad = -1; want = '0;
    for (int i = 0; i < 42; i++)
      if (bad < 0 && a_rd[i*DW +: DW] !== 8'(8'h80 + i)) begin bad = i; want = 8'(8'h80 + i); end
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL oob_low_unchanged lane %0d got %h required %h", bad, a_rd[bad*DW +: DW], want);
    end
`else
    issue(0, 2'b10, 2040, '0, '0);
    bad = -1; want = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [DW-1:0] e;
      e = (i < 8) ? 8'(8'h30 + i) : 8'(8'h80 + i - 8);
      if (bad < 0 && a_rd[i*DW +: DW] !== e) begin bad = i; want = e; end
    end
    n_cmp++;
    if (a_rdv !== 1'b1 || a_err !== 1'b0 || bad >= 0) begin
      n_bad++;
      $display("FAIL wrap_read rdv=%b err=%b lane %0d got %h required 1 0 %h", a_rdv, a_err, bad,
               (bad >= 0) ? a_rd[bad*DW +: DW] : 8'h00, want);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_window_write();
    test_partial_group();
    test_back_to_back();
    test_reserved();
    test_reset_midburst();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/window_mem.md
Name: window_mem

Overview:
Parametrised multi-lane scratch memory for the texture-analysis datapath.
- Stores pixel and feature bytes.
- Serves single-word writes, LANES-wide window writes and LANES-wide window reads through a valid/ready request port.
- Window writes are sequenced over several cycles through WR_PORTS write ports, so the array maps to realistic RAM resources.
- Read data is registered and flagged with rd_valid.

Parameters:
DATA_W, 8, bits per memory word.
DEPTH, 2048, number of words; must be a power of two; ADDR_W = $clog2(DEPTH).
LANES, 50, words per window read/write.
WR_PORTS, 10, words written per clock during a window write; 1 <= WR_PORTS <= LANES.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_op  in  2  00 single write, 01 window write, 10 window read, 11 reserved (ignored, accepted as no-op)
req_addr  in  ADDR_W  base word address
wr_word  in  DATA_W  data for single write
wr_lanes  in  LANES*DATA_W  window write data; lane i at bits [i*DATA_W +: DATA_W], written to base+i
rd_valid  out  1  one-cycle pulse, rd_lanes valid
rd_lanes  out  LANES*DATA_W  window read data, lane i = word at base+i
wr_done  out  1  one-cycle pulse on completion of any write
err  out  1  one-cycle pulse, request rejected (only with WINMEM_BOUNDS_CHECK_EN)

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 from the first clock after release. rd_valid=0, rd_lanes=0, wr_done=0, err=0, state=IDLE. Memory contents are not cleared.
- Accept: a request is accepted on a rising edge where req_valid=1 and req_ready=1. Inputs are sampled only at accept.
- States: IDLE and WBURST.
- IDLE, single write:
  - mem[addr] <= wr_word at the accept edge.
  - wr_done=1 in the next cycle.
  - Stays in IDLE; req_ready stays 1.
- IDLE, window read:
  - rd_lanes is registered at the accept edge from the current array contents, including words written at earlier edges.
  - rd_valid=1 for exactly the following cycle. Latency is 1.
  - Back-to-back reads are allowed every cycle.
- IDLE, window write:
  - All lanes and the base address are latched into a staging register at the accept edge.
  - Group 0 (lanes 0..WR_PORTS-1) is written at that same edge.
  - With G = ceil(LANES/WR_PORTS) > 1: go to WBURST, req_ready=0, and group k is written at the k-th edge after accept.
  - The last group may be partial; only lanes below LANES are written.
  - After the final group: return to IDLE, req_ready=1 in the next cycle, and wr_done pulses in that cycle.
  - With G=1 the block stays in IDLE.
  - A read accepted after req_ready returns sees all lanes of the window write.
- Address arithmetic: base+i is computed modulo DEPTH (ADDR_W-bit wrap) unless the bounds-check feature is enabled.
- Between read pulses, rd_lanes holds its last value; it never drives Z.
- Reserved op: accepted, no state change, no pulses.
- Reset mid-burst: the burst is aborted immediately. Groups already written remain in memory; unwritten groups are dropped. No wr_done pulse is issued.
- Overlapping window lanes during a burst cannot occur, since the base is fixed for the whole burst.

Optional Feature:
Macro WINMEM_BOUNDS_CHECK_EN.
- Defined: a single write, window write or window read with base+LANES > DEPTH (single write: none, always in range) is rejected.
  - No memory change.
  - No rd_valid.
  - err=1 for the cycle after accept.
  - req_ready stays 1.
- Undefined: no check, addresses wrap modulo DEPTH, and err is tied to 0.

Test Plan:
1. Reset, then release; single write addr 1000 data 0x10; window read at 1000 -> rd_valid one cycle after accept, lane0=0x10, wr_done pulsed one cycle after the write.
2. Window write base 200, lane i = i+1 (defaults LANES=50, WR_PORTS=10) -> req_ready low for 4 cycles after accept, wr_done in cycle 5; read at 200 -> lanes 0x01..0x32.
3. LANES=50, WR_PORTS=16 (partial last group) -> 4 groups, req_ready low 3 cycles, lanes 48..49 written in the last group, word base+50 unchanged.
4. Back-to-back reads at 0, 50, 100 on consecutive cycles -> three consecutive rd_valid pulses with the matching windows; req_ready held 1.
5. Assert rst two cycles into a window write at base 400 -> words 400..419 hold new data, 420..449 keep old data; no wr_done; req_ready 1 after release.
6. Window read base 2040: without the macro, lanes 8..49 come from words 0..41; with WINMEM_BOUNDS_CHECK_EN, err pulses, no rd_valid, and memory is unchanged.
